// File: rtl/stf_arb_pkg.sv
// Shared types and helpers for the fast-domain request arbiter.
package stf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr,
// ascending and wrapping modulo N.
module rr_pick
  import stf_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]          elig,
  input  logic [sel_w(N)-1:0]   ptr,
  output logic                  hit,
  output logic [sel_w(N)-1:0]   idx
);

  localparam int SW = sel_w(N);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  logic [SW-1:0] cand;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = ptr;
    for (int k = 0; k < N; k++) begin
      if (!hit && elig[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
      cand = (cand == LAST) ? '0 : cand + SW'(1);
    end
  end

endmodule

// File: rtl/stf_req_arbiter.sv
// Round-robin arbiter granting one shared resource to N synchronized requesters,
// with a per-grant timeout and four-phase ack levels back to the slow side.
module stf_req_arbiter
  import stf_arb_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                fastclk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_sync,
  output logic [N-1:0]        ack,
  output logic                res_start,
  output logic [sel_w(N)-1:0] res_sel,
  input  logic                res_done,
  output logic                busy,
  output logic [N-1:0]        err,
  input  logic                err_clr
);

  localparam int SW = sel_w(N);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(N - 1);

  arb_state_t    state, state_nxt;
  logic [SW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [N-1:0]  elig;
  logic          pick_hit;
  logic [SW-1:0] pick_idx;
  logic          done_hit, to_hit, finish;
  logic [N-1:0]  sel_oh, ack_set, err_set;

  assign elig = req_sync & ~ack;

  rr_pick #(.N(N)) u_pick (
    .elig (elig),
    .ptr  (ptr),
    .hit  (pick_hit),
    .idx  (pick_idx)
  );

  // A completion on the last counting cycle beats the timeout.
  assign done_hit = (state == WAIT_DONE) && res_done;
  assign to_hit   = (state == WAIT_DONE) && !res_done && (cnt == CNT_LAST);
  assign finish   = done_hit || to_hit;

  assign sel_oh  = {{(N-1){1'b0}}, 1'b1} << res_sel;
  assign ack_set = finish ? sel_oh : '0;
  assign err_set = to_hit ? sel_oh : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pick_hit) state_nxt = START;
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (finish) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      res_sel   <= '0;
      ptr       <= '0;
      cnt       <= '0;
      res_start <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      res_start <= (state == IDLE) && pick_hit;
      busy      <= (state_nxt != IDLE);
      if (state == IDLE && pick_hit)
        res_sel <= pick_idx;
      if (finish)
        ptr <= (res_sel == SEL_LAST) ? '0 : res_sel + SW'(1);
      if (state == START)
        cnt <= '0;
      else if (state == WAIT_DONE && cnt != '1)
        cnt <= cnt + CW'(1);
    end
  end

  // Ack release is independent of the FSM; a set on the same bit always wins.
  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= '0;
      err <= '0;
    end else begin
      ack <= (ack & req_sync) | ack_set;
      err <= (err_clr ? '0 : err) | err_set;
    end
  end

endmodule

// File: tb/tb_stf_req_arbiter.sv
// Directed bench: N=2 and N=4 arbiters, both with TIMEOUT=8.
module tb_stf_req_arbiter;

  logic fastclk = 1'b0;
  logic rst_n;

  logic [1:0] req2, ack2, err2;
  logic       start2, sel2, done2, busy2, clr2;
  logic [3:0] req4, ack4, err4;
  logic [1:0] sel4;
  logic       start4, done4, busy4, clr4;

  int checks = 0;
  int errors = 0;

  always #5 fastclk = ~fastclk;

  stf_req_arbiter #(.N(2), .TIMEOUT(8)) dut2 (
    .fastclk (fastclk), .rst_n (rst_n), .req_sync (req2), .ack (ack2),
    .res_start (start2), .res_sel (sel2), .res_done (done2), .busy (busy2),
    .err (err2), .err_clr (clr2)
  );

  stf_req_arbiter #(.N(4), .TIMEOUT(8)) dut4 (
    .fastclk (fastclk), .rst_n (rst_n), .req_sync (req4), .ack (ack4),
    .res_start (start4), .res_sel (sel4), .res_done (done4), .busy (busy4),
    .err (err4), .err_clr (clr4)
  );

  task automatic step;
    @(posedge fastclk);
    #1;
  endtask

  task automatic do_reset;
    req2 = '0; done2 = 1'b0; clr2 = 1'b0;
    req4 = '0; done4 = 1'b0; clr4 = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_start2(input string name);
    int n = 0;
    while (!start2 && n < 8) begin step(); n++; end
    checks++;
    if (start2 !== 1'b1) begin errors++; $display("FAIL %s start2: got %b want 1", name, start2); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req2 = '0; done2 = 1'b0; clr2 = 1'b0;
    req4 = '0; done4 = 1'b0; clr4 = 1'b0;
    #12;
    checks++;
    if ({ack2, err2, start2, sel2, busy2} !== 7'b0) begin
      errors++; $display("FAIL reset2: got %b want 0", {ack2, err2, start2, sel2, busy2});
    end
    checks++;
    if ({ack4, err4, start4, sel4, busy4} !== 12'b0) begin
      errors++; $display("FAIL reset4: got %b want 0", {ack4, err4, start4, sel4, busy4});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single;
    do_reset();
    req2 = 2'b01;
    step();
    checks++;
    if ({start2, sel2, busy2} !== 3'b101) begin
      errors++; $display("FAIL single_grant: got %b want 101", {start2, sel2, busy2});
    end
    step();
    checks++;
    if ({start2, busy2} !== 2'b01) begin
      errors++; $display("FAIL single_wait: got %b want 01", {start2, busy2});
    end
    step();
    done2 = 1'b1;
    step();
    done2 = 1'b0;
    checks++;
    if ({ack2, busy2} !== 3'b010) begin
      errors++; $display("FAIL single_ack: got %b want 010", {ack2, busy2});
    end
    step();
    checks++;
    if ({ack2, start2} !== 3'b010) begin
      errors++; $display("FAIL single_no_regrant: got %b want 010", {ack2, start2});
    end
    req2 = 2'b00;
    step();
    checks++;
    if (ack2 !== 2'b00) begin errors++; $display("FAIL single_ack_drop: got %b want 00", ack2); end
  endtask

  task automatic test_simultaneous;
    do_reset();
    req2 = 2'b11;
    for (int g = 0; g < 4; g++) begin
      logic exp = 1'(g % 2);
      wait_start2("rr");
      checks++;
      if (sel2 !== exp) begin errors++; $display("FAIL rr_sel[%0d]: got %0d want %0d", g, sel2, exp); end
      step();
      done2 = 1'b1;
      step();
      done2 = 1'b0;
      checks++;
      if (ack2[exp] !== 1'b1) begin errors++; $display("FAIL rr_ack[%0d]: got %b want 1", g, ack2[exp]); end
      req2[exp] = 1'b0;
      step();
      checks++;
      if (ack2[exp] !== 1'b0) begin errors++; $display("FAIL rr_drop[%0d]: got %b want 0", g, ack2[exp]); end
      req2[exp] = 1'b1;
    end
    req2 = 2'b00;
  endtask

  task automatic test_timeout;
    do_reset();
    req2 = 2'b10;
    wait_start2("timeout");
    for (int i = 0; i < 8; i++) step();
    checks++;
    if ({err2, ack2, busy2} !== 5'b00001) begin
      errors++; $display("FAIL timeout_early: got %b want 00001", {err2, ack2, busy2});
    end
    step();
    checks++;
    if ({err2, ack2, busy2} !== 5'b10100) begin
      errors++; $display("FAIL timeout_fire: got %b want 10100", {err2, ack2, busy2});
    end
    step();
    step();
    checks++;
    if (err2 !== 2'b10) begin errors++; $display("FAIL err_sticky: got %b want 10", err2); end
    clr2 = 1'b1;
    step();
    clr2 = 1'b0;
    checks++;
    if (err2 !== 2'b00) begin errors++; $display("FAIL err_clr: got %b want 00", err2); end
    req2 = 2'b00;
    step();
  endtask

  task automatic test_tie;
    do_reset();
    req2 = 2'b01;
    wait_start2("tie");
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (ack2 !== 2'b00) begin errors++; $display("FAIL tie_pre: got %b want 00", ack2); end
    done2 = 1'b1;
    step();
    done2 = 1'b0;
    checks++;
    if ({ack2, err2} !== 4'b0100) begin
      errors++; $display("FAIL tie_done_wins: got %b want 0100", {ack2, err2});
    end
    req2 = 2'b00;
    step();
  endtask

  task automatic test_stray;
    do_reset();
    done2 = 1'b1;
    step();
    done2 = 1'b0;
    checks++;
    if ({busy2, start2, ack2} !== 4'b0) begin
      errors++; $display("FAIL stray_done: got %b want 0000", {busy2, start2, ack2});
    end
    req2 = 2'b10;
    wait_start2("midreset");
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ack2, err2, start2, sel2, busy2} !== 7'b0) begin
      errors++; $display("FAIL midreset_outputs: got %b want 0", {ack2, err2, start2, sel2, busy2});
    end
    req2 = 2'b00;
    #2;
    rst_n = 1'b1;
    step();
    done2 = 1'b1;
    step();
    done2 = 1'b0;
    step();
    checks++;
    if ({ack2, err2, busy2, start2} !== 6'b0) begin
      errors++; $display("FAIL late_done: got %b want 0", {ack2, err2, busy2, start2});
    end
  endtask

  task automatic test_back_to_back_n4;
    do_reset();
    req4 = 4'b0001;
    step();
    checks++;
    if ({start4, sel4} !== 3'b100) begin errors++; $display("FAIL n4_grant0: got %b want 100", {start4, sel4}); end
    step();
    done4 = 1'b1;
    step();
    done4 = 1'b0;
    checks++;
    if (ack4 !== 4'b0001) begin errors++; $display("FAIL n4_ack0: got %b want 0001", ack4); end
    req4 = 4'b0101;
    step();
    checks++;
    if ({start4, sel4} !== 3'b110) begin errors++; $display("FAIL n4_grant2: got %b want 110", {start4, sel4}); end
    step();
    req4 = 4'b0100;
    step();
    checks++;
    if ({ack4, sel4, busy4} !== 7'b0000101) begin
      errors++; $display("FAIL n4_drop_during_wait: got %b want 0000101", {ack4, sel4, busy4});
    end
    done4 = 1'b1;
    step();
    done4 = 1'b0;
    checks++;
    if ({ack4, err4} !== 8'b01000000) begin
      errors++; $display("FAIL n4_ack2: got %b want 01000000", {ack4, err4});
    end
    req4 = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_timeout();
    test_tie();
    test_stray();
    test_back_to_back_n4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stf_req_arbiter.md
# stf_req_arbiter

Fast-domain arbiter that shares one resource (sample-memory/reader port) among N slow-domain requesters. Requests arrive as level signals already passed through `stf_sync` into `fastclk`. The block grants requesters round-robin, issues a start pulse, waits for completion or timeout, and answers each requester with a four-phase ack level that the slow side synchronizes back.

## Interface
- `N`, 2: number of requesters; must match the `N` of the feeding `stf_sync`; range 2–8.
- `TIMEOUT`, 255: maximum cycles in WAIT_DONE before the request is abandoned; range 1–65535.
- `fastclk`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_sync`  in  N  synchronized request levels, one per requester.
- `ack`  out  N  per-requester acknowledge levels, four-phase.
- `res_start`  out  1  one-cycle start pulse to the shared resource.
- `res_sel`  out  $clog2(N)  index of the granted requester.
- `res_done`  in  1  one-cycle completion pulse from the resource.
- `busy`  out  1  high in START and WAIT_DONE.
- `err`  out  N  sticky timeout flags, one per requester.
- `err_clr`  in  1  pulse; clears all `err` bits.

## Operation
- Requester i is eligible when `req_sync[i]`=1 and `ack[i]`=0.
- FSM states and transitions:
  - IDLE → START when any requester is eligible. Latch `res_sel` from the round-robin pick.
  - START: `res_start`=1 for exactly this cycle; clear the timeout counter; → WAIT_DONE.
  - WAIT_DONE, with `res_done`=1: set `ack[res_sel]`; set pointer = (`res_sel`+1) mod N; → IDLE.
  - WAIT_DONE, with counter = TIMEOUT−1 and no `res_done`: set `err[res_sel]` and `ack[res_sel]`; advance the pointer as above; → IDLE.
- Round-robin: search eligible bits starting at the pointer, ascending, wrapping mod N; the first hit wins. Pointer resets to 0.
- Ack release runs independently of the FSM. If `ack[i]`=1 and `req_sync[i]`=0, clear `ack[i]` next cycle. This can happen in any state and for any i, including the currently selected requester.
- `res_done` outside WAIT_DONE is ignored. The resource must take at least one cycle after `res_start`.
- Timeout counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.
- `err_clr` and an `err` set in the same cycle: the set wins for that bit; all other bits clear.

## Timing
- Reset values: state IDLE; `ack`=0, `err`=0, `res_start`=0, `busy`=0, `res_sel`=0, pointer=0, counter=0.
- Grant latency: eligible in IDLE at cycle k → `res_start`=1 and `res_sel` valid at k+1. `res_sel` holds until the FSM re-enters IDLE.
- Completion: `res_done` at cycle m → `ack` bit high and state IDLE at m+1. A new START is possible at m+2.
- Timeout: if no `res_done` arrives, `err` and `ack` rise exactly TIMEOUT+1 cycles after `res_start`.
- `res_done` on the same cycle the counter reaches TIMEOUT−1: done wins and `err` stays 0.
- Ack drop: `req_sync[i]` seen low at cycle p → `ack[i]`=0 at p+1.
- Requester i cannot be re-granted until its `ack[i]` has dropped and `req_sync[i]` rises again.
- Asynchronous reset mid-operation: all outputs return to their reset values immediately. An in-flight resource operation is abandoned and its later `res_done` is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `stf_arb_pkg` holds:
  - the state enum `arb_state_t` {IDLE, START, WAIT_DONE};
  - the function `sel_w(N)` returning $clog2(N).
- Sub-module `rr_pick`: purely combinational. Inputs are the eligible vector and the pointer; outputs are `hit` and `idx`. Parameterized by N.
- Top level contains the FSM, the ack/err registers, and the timeout counter.

## Test plan
- Single request: reset with N=2; raise `req_sync[0]` → `res_start` one cycle later with `res_sel`=0. `res_done` three cycles later → `ack[0]`=1 next cycle. Drop `req_sync[0]` → `ack[0]`=0 one cycle later.
- Simultaneous requests: raise `req_sync`=2'b11 in one cycle → grants in order 0 then 1. With both held and re-requested after each ack drop, grants continue to alternate 0,1,0,1.
- Timeout: TIMEOUT=8, no `res_done` → `err[sel]` and `ack[sel]` rise 9 cycles after `res_start`. `err` persists until `err_clr`.
- Done/timeout tie: TIMEOUT=8 with `res_done` on the final counting cycle → `ack` rises and `err` stays 0.
- Stray and late pulses: `res_done` in IDLE → no state change. Assert `rst_n`=0 in WAIT_DONE → all outputs reset immediately, and a subsequent `res_done` is ignored.
- Ack drop during another grant: N=4; drop `req_sync[0]` while requester 2 is in WAIT_DONE → `ack[0]` clears next cycle without disturbing `res_sel`=2.
